// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divide unit: FSM encoding and defaults.
package div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    // Replicated across the result width to form the all-ones divide-by-zero quotient.
    localparam logic DBZ_QUOT_BIT = 1'b1;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the execute-stage controller and the divide unit.
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             busy;
    logic             done;
    logic             dbz;

    modport master (
        output start, sgn, A, B,
        input  quot, rem, busy, done, dbz
    );

    modport slave (
        input  start, sgn, A, B,
        output quot, rem, busy, done, dbz
    );
endinterface

// File: rtl/div_unit_adder.sv
// Ripple-style carry adder reused for the divider's trial subtraction.
module div_unit_adder #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/div_unit.sv
// Restoring shift-subtract divider, one quotient bit per clock, signed or unsigned.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic      clk,
    input  logic      reset,
    div_unit_if.slave bus
);
    state_t           state;
    state_t           nextState;
    logic [WIDTH:0]   remReg;
    logic [WIDTH-1:0] qReg;
    logic [WIDTH-1:0] dReg;
    logic [CNT_W-1:0] cnt;
    logic             aNeg;
    logic             qNeg;
    logic [WIDTH-1:0] quotReg;
    logic [WIDTH-1:0] remOut;
    logic             dbzReg;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             carry;
    logic             nonNeg;

    assign magA = (bus.sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign magB = (bus.sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    assign shifted = {remReg[WIDTH-1:0], qReg[WIDTH-1]};

    div_unit_adder #(.W(WIDTH + 1)) trialSub (
        .a    (shifted),
        .b    (~{1'b0, dReg}),
        .cin  (1'b1),
        .sum  (trial),
        .cout (carry)
    );

    // A set top remainder bit would mean the shifted value already exceeds any divisor.
    assign nonNeg = carry | remReg[WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    nextState = (bus.B == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_W'(1)) begin
                    nextState = FIX;
                end
            end
            FIX:     nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remReg  <= '0;
            qReg    <= '0;
            dReg    <= '0;
            cnt     <= '0;
            aNeg    <= 1'b0;
            qNeg    <= 1'b0;
            quotReg <= '0;
            remOut  <= '0;
            dbzReg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        aNeg   <= bus.sgn & bus.A[WIDTH-1];
                        qNeg   <= bus.sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        dReg   <= magB;
                        qReg   <= magA;
                        remReg <= '0;
                        cnt    <= CNT_W'(WIDTH);
                        // Divide-by-zero skips the iterations and publishes immediately.
                        if (bus.B == '0) begin
                            quotReg <= {WIDTH{DBZ_QUOT_BIT}};
                            remOut  <= bus.A;
                            dbzReg  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    remReg <= nonNeg ? trial : shifted;
                    qReg   <= {qReg[WIDTH-2:0], nonNeg};
                    cnt    <= cnt - CNT_W'(1);
                end
                FIX: begin
                    quotReg <= qNeg ? -qReg : qReg;
                    remOut  <= aNeg ? -remReg[WIDTH-1:0] : remReg[WIDTH-1:0];
                    dbzReg  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.quot = quotReg;
    assign bus.rem  = remOut;
    assign bus.dbz  = dbzReg;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized operations against an arithmetic model.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int W = 32;
    localparam int LAT = W + 2;

    logic clk;
    logic reset;
    int   cyc;
    int   tests;
    int   failed;

    bit          mActive;
    int          mStart;
    int          mDone;
    logic [W-1:0] pQuot, pRem, hQuot, hRem;
    bit          pDbz, hDbz;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference result straight from integer division semantics.
    function automatic void model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output bit z);
        longint sa, sb, qq, rr;
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            qq = sa / sb;
            rr = sa % sb;
            q = qq[W-1:0];
            r = rr[W-1:0];
            z = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    task automatic applyStimulus(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output int issued);
        @(posedge clk);
        #2;
        bus.start = 1'b1;
        bus.sgn   = s;
        bus.A     = a;
        bus.B     = b;
        issued    = cyc;
        if (!mActive || cyc > mDone) begin
            model(s, a, b, pQuot, pRem, pDbz);
            mActive = 1'b1;
            mStart  = cyc;
            mDone   = cyc + ((b == 0) ? 1 : LAT);
        end
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        bus.sgn   = 1'($urandom);
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    task automatic waitDone(output int at);
        at = -1;
        for (int i = 0; i < LAT + 6; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) checkOutput("doneTimeout", 64'd0, 64'd1);
    endtask

    task automatic runDirected(input string name, input bit s, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] eQ,
                               input logic [W-1:0] eR, input bit eZ, input int eLat);
        int issued, at;
        applyStimulus(s, a, b, issued);
        waitDone(at);
        checkOutput({name, "Latency"}, 64'(at - issued), 64'(eLat));
        checkOutput({name, "Quot"}, 64'(bus.quot), 64'(eQ));
        checkOutput({name, "Rem"}, 64'(bus.rem), 64'(eR));
        checkOutput({name, "Dbz"}, 64'(bus.dbz), 64'(eZ));
    endtask

    // Per-cycle comparison of every output against the model timeline.
    always @(negedge clk) begin
        bit expBusy, expDone;
        expBusy = mActive && (cyc > mStart) && (cyc <= mDone);
        expDone = mActive && (cyc == mDone);
        checkOutput("busy", 64'(bus.busy), 64'(expBusy));
        checkOutput("done", 64'(bus.done), 64'(expDone));
        if (mActive && cyc >= mDone) begin
            hQuot = pQuot;
            hRem  = pRem;
            hDbz  = pDbz;
        end
        if (!mActive || cyc >= mDone) begin
            checkOutput("quot", 64'(bus.quot), 64'(hQuot));
            checkOutput("rem", 64'(bus.rem), 64'(hRem));
            checkOutput("dbz", 64'(bus.dbz), 64'(hDbz));
        end
    end

    initial begin
        int issued, at, pick;
        logic [W-1:0] ra, rb;
        bit rs;

        tests = 0;
        failed = 0;
        cyc = 0;
        mActive = 1'b0;
        mStart = 0;
        mDone = 0;
        hQuot = '0;
        hRem = '0;
        hDbz = 1'b0;
        pQuot = '0;
        pRem = '0;
        pDbz = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.sgn = 1'b0;
        bus.A = '0;
        bus.B = '0;

        repeat (2) @(negedge clk);
        checkOutput("resetQuot", 64'(bus.quot), 64'd0);
        checkOutput("resetRem", 64'(bus.rem), 64'd0);
        checkOutput("resetBusy", 64'(bus.busy), 64'd0);
        checkOutput("resetDone", 64'(bus.done), 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        runDirected("unsigned", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
        runDirected("signedMix", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34);
        runDirected("divZero", 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1);
        runDirected("overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 34);

        // Second start during the operation must be ignored.
        applyStimulus(1'b0, 32'd50, 32'd5, issued);
        repeat (7) @(posedge clk);
        applyStimulus(1'b0, 32'd9, 32'd3, at);
        waitDone(at);
        checkOutput("restartLatency", 64'(at - issued), 64'd34);
        checkOutput("restartQuot", 64'(bus.quot), 64'd10);
        checkOutput("restartRem", 64'(bus.rem), 64'd0);
        runDirected("reissue", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

        // Reset fifteen cycles into an operation discards it.
        applyStimulus(1'b0, 32'd1000, 32'd3, issued);
        repeat (14) @(posedge clk);
        #2;
        reset = 1'b1;
        mActive = 1'b0;
        hQuot = '0;
        hRem = '0;
        hDbz = 1'b0;
        @(negedge clk);
        checkOutput("midResetBusy", 64'(bus.busy), 64'd0);
        checkOutput("midResetDone", 64'(bus.done), 64'd0);
        checkOutput("midResetQuot", 64'(bus.quot), 64'd0);
        checkOutput("midResetRem", 64'(bus.rem), 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        runDirected("afterReset", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 34);

        for (int n = 0; n < 60; n++) begin
            rs = 1'($urandom);
            pick = $urandom_range(0, 7);
            ra = (pick == 0) ? 32'h80000000 : (pick == 1) ? 32'($urandom_range(0, 200)) : $urandom;
            pick = $urandom_range(0, 9);
            case (pick)
                0:       rb = 32'd0;
                1:       rb = 32'd1;
                2:       rb = 32'hFFFFFFFF;
                3:       rb = 32'($urandom_range(2, 15));
                default: rb = $urandom;
            endcase
            applyStimulus(rs, ra, rb, issued);
            if (rb != 0 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 20)) @(posedge clk);
                applyStimulus(1'($urandom), $urandom, $urandom, at);
            end
            waitDone(at);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
